// File: rtl/reg_mem_dp.sv
// rtl/reg_mem_dp.sv - dual-port register memory with per-bit write mask and sequential clear sweep.
// Optional macro REG_MEM_DP_BYPASS_EN: same-address read during write returns the merged write value.
module reg_mem_dp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    input  logic                  ren,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_BITS-1:0]  clr_cnt;
    logic [ADDR_BITS-1:0]  clr_cnt_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word;

    assign wr_merged = (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    assign busy      = (state == ST_CLEAR);

`ifdef REG_MEM_DP_BYPASS_EN
    assign rd_word = (wen && (wr_addr == rd_addr)) ? wr_merged : mem[rd_addr];
`else
    assign rd_word = mem[rd_addr];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        mem_we       = 1'b0;
        mem_waddr    = wr_addr;
        mem_wdata    = wr_merged;
        rd_en        = 1'b0;
        case (state)
            ST_IDLE: begin
                mem_we = wen;
                rd_en  = ren;
                if (clr) begin
                    state_next   = ST_CLEAR;
                    clr_cnt_next = '0;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
                mem_wdata = '0;
                // Stop on the last address instead of wrapping so no word is cleared twice.
                if (clr_cnt == LAST_ADDR) begin
                    state_next = ST_IDLE;
                end else begin
                    clr_cnt_next = clr_cnt + ADDR_BITS'(1);
                end
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word;
            end
        end
    end

endmodule

// File: doc/reg_mem_dp.md
REG_MEM_DP -- requirements
Module: reg_mem_dp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: word width in bits.
REQ-002 SHALL have parameter ADDR_BITS, default 5: address width; DEPTH = 2**ADDR_BITS words (derived, not overridable).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wen  input  1  write enable.
REQ-006 SHALL have port wr_addr  input  ADDR_BITS  write address.
REQ-007 SHALL have port wr_data  input  DATA_WIDTH  write data.
REQ-008 SHALL have port wr_mask  input  DATA_WIDTH  per-bit write mask (1 = bit updated).
REQ-009 SHALL have port ren  input  1  read enable.
REQ-010 SHALL have port rd_addr  input  ADDR_BITS  read address.
REQ-011 SHALL have port clr  input  1  single-cycle request to start a full-memory clear sweep.
REQ-012 SHALL have port rd_data  output  DATA_WIDTH  registered read data.
REQ-013 SHALL have port rd_valid  output  1  high for one cycle when rd_data carries new read data.
REQ-014 SHALL have port busy  output  1  high while the clear sweep runs; reads and writes are ignored.

Function
REQ-015 SHALL use a two-state FSM: IDLE and CLEAR, with a clear counter clr_cnt of ADDR_BITS bits.
REQ-016 In IDLE, a clk edge with wen=1 SHALL set mem[wr_addr] to (old & ~wr_mask) | (wr_data & wr_mask).
REQ-017 In IDLE, a clk edge with ren=1 SHALL load rd_data from mem[rd_addr] and set rd_valid=1 (1-cycle latency).
REQ-018 With ren=0, or while busy, rd_valid SHALL be 0 and rd_data SHALL hold its previous value.
REQ-019 Simultaneous read and write to different addresses in the same cycle SHALL both complete.
REQ-020 In IDLE, clr=1 SHALL move the FSM to CLEAR with clr_cnt=0 and busy=1 on the next edge; a wen/ren in that same cycle SHALL still be performed.
REQ-021 In CLEAR, each edge SHALL write 0 to mem[clr_cnt] and increment clr_cnt; wen, ren and clr SHALL be ignored.
REQ-022 After the edge that clears address DEPTH-1, the FSM SHALL return to IDLE with busy=0; busy SHALL therefore be high for exactly DEPTH cycles.
REQ-023 clr_cnt SHALL reach DEPTH-1 without wrapping past it; no address SHALL be cleared twice in one sweep.

Reset
REQ-024 rst=1 at an edge SHALL force state=CLEAR, clr_cnt=0, busy=1, rd_valid=0 and rd_data=0, with no memory write on that edge.
REQ-025 While rst is held, the block SHALL remain in that state; the sweep SHALL start on the first edge with rst=0.
REQ-026 rst asserted during a sweep SHALL restart the sweep from address 0.
REQ-027 rst SHALL take priority over clr, wen and ren.

Configuration
REQ-028 The macro REG_MEM_DP_BYPASS_EN SHALL control read-during-write behaviour to the same address in IDLE.
REQ-029 With REG_MEM_DP_BYPASS_EN defined, rd_data SHALL return the newly merged write value.
REQ-030 Without REG_MEM_DP_BYPASS_EN, rd_data SHALL return the value stored before the write.

Verification (DATA_WIDTH=8, ADDR_BITS=5)
REQ-031 Pulse rst, then release -> busy=1 for exactly 32 cycles; reading addresses 0..31 afterwards returns 0 each time, with rd_valid=1 one cycle after each ren.
REQ-032 Write values 10..41 to addresses 0..31 with wr_mask=0xFF, then read addresses 0..31 -> rd_data = address+10.
REQ-033 Write 0xFF to address 3, then write 0x00 with wr_mask=0x0F, then read address 3 -> 0xF0.
REQ-034 With address 7 holding 0x11, write 0x55 to address 7 and read address 7 in the same cycle -> 0x55 with REG_MEM_DP_BYPASS_EN, 0x11 without.
REQ-035 Pulse clr in IDLE, then issue wen to address 5 during busy -> busy for 32 cycles; rd_valid stays 0 during busy; all addresses, including 5, read 0 afterwards.
REQ-036 Assert rst on the 10th cycle of a clear sweep -> sweep restarts at 0; busy stays high for 32 cycles after rst deasserts.
